// File: rtl/tlc_arbiter.sv
// Two-street traffic light arbiter with pedestrian phase; Moore FSM, round-robin service via all-red.
// Outputs are registered state decodes; async reset forces the all-red phase immediately.
module tlc_arbiter #(
   parameter int unsigned MIN_GREEN = 4,
   parameter int unsigned MAX_GREEN = 10,
   parameter int unsigned YELLOW    = 2,
   parameter int unsigned ALLRED    = 1,
   parameter int unsigned WALK      = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Ta,
   input  logic       Tb,
   input  logic       ped_btn,
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      RR = 3'd0,
      GA = 3'd1,
      YA = 3'd2,
      GB = 3'd3,
      YB = 3'd4,
      WK = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      SRV_A = 2'd0,
      SRV_B = 2'd1,
      SRV_P = 2'd2
   } srv_t;

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_RED    = 2'b10;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_cnt;
   logic       r_ped_pend;
   srv_t       r_last;
   srv_t       w_grant;
   logic       w_any;
   logic       w_chg;
   logic [8:0] w_cnt1;

   // Cycles spent in the current state including this one; keeps thresholds free of N-1 underflow.
   assign w_cnt1 = {1'b0, r_cnt} + 9'd1;
   assign w_any  = Ta | Tb | r_ped_pend;
   assign w_chg  = (w_next != r_state);

   always_comb begin
      w_grant = SRV_A;
      case (r_last)
         SRV_A:   w_grant = Tb ? SRV_B : (r_ped_pend ? SRV_P : SRV_A);
         SRV_B:   w_grant = r_ped_pend ? SRV_P : (Ta ? SRV_A : SRV_B);
         default: w_grant = Ta ? SRV_A : (Tb ? SRV_B : SRV_P);
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RR: begin
            if (w_any && (w_cnt1 >= 9'(ALLRED))) begin
               case (w_grant)
                  SRV_A:   w_next = GA;
                  SRV_B:   w_next = GB;
                  default: w_next = WK;
               endcase
            end
         end
         GA: if ((w_cnt1 >= 9'(MIN_GREEN)) &&
                 (!Ta || ((Tb | r_ped_pend) && (w_cnt1 >= 9'(MAX_GREEN))))) w_next = YA;
         GB: if ((w_cnt1 >= 9'(MIN_GREEN)) &&
                 (!Tb || ((Ta | r_ped_pend) && (w_cnt1 >= 9'(MAX_GREEN))))) w_next = YB;
         YA: if (w_cnt1 == 9'(YELLOW)) w_next = RR;
         YB: if (w_cnt1 == 9'(YELLOW)) w_next = RR;
         WK: if (w_cnt1 == 9'(WALK)) w_next = RR;
         default: w_next = RR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= RR;
         r_cnt      <= 8'd0;
         r_ped_pend <= 1'b0;
         r_last     <= SRV_P;
      end else begin
         r_state <= w_next;
         if (w_chg)               r_cnt <= 8'd0;
         else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
         // A button press on the WK entry edge wins over the clear.
         r_ped_pend <= ped_btn | (r_ped_pend & ~(w_chg && (w_next == WK)));
         if (w_chg) begin
            case (w_next)
               GA:      r_last <= SRV_A;
               GB:      r_last <= SRV_B;
               WK:      r_last <= SRV_P;
               default: r_last <= r_last;
            endcase
         end
      end
   end

   always_comb begin
      La   = L_RED;
      Lb   = L_RED;
      walk = 1'b0;
      case (r_state)
         GA:      La = L_GREEN;
         YA:      La = L_YELLOW;
         GB:      Lb = L_GREEN;
         YB:      Lb = L_YELLOW;
         WK:      walk = 1'b1;
         default: ;
      endcase
   end

   assign phase = r_state;

endmodule
